// File: rtl/dsram_ctrl_if.sv
// Data-side SRAM controller bus bundle: core request/response signals
// plus the external 32-bit SRAM pin group.
//   slave  : controller view (drives rdata/done/busy and all sram_* strobes)
//   master : core + SRAM model view (drives requests and sram_dout)
interface dsram_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              req_read;
    logic              req_write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        byte_en;
    logic [31:0]       rdata;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;
    logic              sram_data_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [3:0]        sram_be_n;

    modport slave (
        input  req_read, req_write, addr, wdata, byte_en, sram_dout,
        output rdata, done, busy, sram_addr, sram_din, sram_data_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport master (
        output req_read, req_write, addr, wdata, byte_en, sram_dout,
        input  rdata, done, busy, sram_addr, sram_din, sram_data_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/dsram_ctrl.sv
// Unified data-side external SRAM controller: word reads, byte-masked
// writes, programmable wait states, one-cycle done pulse.
// Ports: clk, rst (async, active-low), bus (dsram_ctrl_if.slave).
module dsram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    dsram_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt;
    logic              w_cap;
    logic              w_start_rd;
    logic              w_start_wr;
    logic              w_wr_state;

    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_din;
    logic              r_data_oe;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [3:0]        r_be_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt      = r_cnt;
        w_cap      = 1'b0;
        w_start_rd = 1'b0;
        w_start_wr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_read) begin
                    w_next     = RD;
                    w_cnt      = '0;
                    w_start_rd = 1'b1;
                end else if (bus.req_write) begin
                    // an all-zero byte mask completes without touching the SRAM
                    if (|bus.byte_en) begin
                        w_next     = WR_SETUP;
                        w_start_wr = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            RD: begin
                if (r_cnt == RD_LAST) begin
                    w_next = DONE;
                    w_cnt  = '0;
                    w_cap  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            WR_SETUP: begin
                w_next = WR_PULSE;
                w_cnt  = '0;
            end
            WR_PULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_next = WR_HOLD;
                    w_cnt  = '0;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            WR_HOLD: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_wr_state = (w_next == WR_SETUP) || (w_next == WR_PULSE) ||
                        (w_next == WR_HOLD);

    // Strobes are decoded from the next state so every pin is a flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_data_oe <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_be_n    <= 4'hF;
        end else begin
            if (w_start_rd || w_start_wr) begin
                r_addr <= bus.addr[ADDR_W+1:2];
            end
            if (w_start_wr) begin
                r_din <= bus.wdata;
            end
            if (w_cap) begin
                r_rdata <= bus.sram_dout;
            end
            r_done    <= (w_next == DONE);
            r_busy    <= (w_next != IDLE);
            r_ce_n    <= !((w_next == RD) || w_wr_state);
            r_oe_n    <= (w_next != RD);
            r_we_n    <= (w_next != WR_PULSE);
            r_data_oe <= w_wr_state;
            unique case (w_next)
                RD:       r_be_n <= 4'h0;
                WR_SETUP: r_be_n <= ~bus.byte_en;
                WR_PULSE: r_be_n <= r_be_n;
                WR_HOLD:  r_be_n <= r_be_n;
                default:  r_be_n <= 4'hF;
            endcase
        end
    end

    assign bus.rdata        = r_rdata;
    assign bus.done         = r_done;
    assign bus.busy         = r_busy;
    assign bus.sram_addr    = r_addr;
    assign bus.sram_din     = r_din;
    assign bus.sram_data_oe = r_data_oe;
    assign bus.sram_ce_n    = r_ce_n;
    assign bus.sram_oe_n    = r_oe_n;
    assign bus.sram_we_n    = r_we_n;
    assign bus.sram_be_n    = r_be_n;

endmodule

// File: tb/tb_dsram_ctrl.sv
// Self-checking bench for dsram_ctrl: vector table of single accesses
// against a byte-lane SRAM model, plus reset and back-to-back sequences.
module tb_dsram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dsram_ctrl_if #(.ADDR_W(20)) bus ();

    dsram_ctrl #(.ADDR_W(20), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;
    int v_overlap = 0;
    int v_doe = 0;
    int v_stable = 0;

    assign bus.sram_dout = (!bus.sram_ce_n && !bus.sram_oe_n) ?
                           mem[bus.sram_addr[7:0]] : 32'h0;

    // word is committed when we_n rises with the chip still selected
    always @(posedge bus.sram_we_n) begin
        if (rst === 1'b1 && bus.sram_ce_n === 1'b0 && bus.sram_data_oe === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.sram_be_n[b])
                    mem[bus.sram_addr[7:0]][8*b +: 8] = bus.sram_din[8*b +: 8];
            end
        end
    end

    logic        prev_low = 1'b0;
    logic [55:0] prev_pins;
    always @(negedge clk) begin
        if (rst) begin
            if (!bus.sram_oe_n && !bus.sram_we_n) v_overlap++;
            if (bus.sram_data_oe && (!bus.sram_oe_n || bus.sram_ce_n)) v_doe++;
            if (!bus.sram_we_n) begin
                if (prev_low && prev_pins !== {bus.sram_addr, bus.sram_din, bus.sram_be_n})
                    v_stable++;
                prev_low  = 1'b1;
                prev_pins = {bus.sram_addr, bus.sram_din, bus.sram_be_n};
            end else begin
                prev_low = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(
        input  logic rd, input logic wr,
        input  logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
        output int lat, output int ce, output int we, output int oe, output int bsy,
        output logic [19:0] sa, output logic [3:0] sbe,
        output logic [31:0] rdv, output logic post_ok
    );
        lat = -1; ce = 0; we = 0; oe = 0; bsy = 0;
        sa = '0; sbe = 4'hF; rdv = '0; post_ok = 1'b0;
        @(negedge clk);
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        bus.byte_en   = be;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!bus.sram_ce_n) begin ce++; sa = bus.sram_addr; end
            if (!bus.sram_oe_n) oe++;
            if (!bus.sram_we_n) begin we++; sbe = bus.sram_be_n; end
            if (bus.busy) bsy++;
            if (bus.done) begin
                lat = i;
                rdv = bus.rdata;
                break;
            end
        end
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        @(posedge clk); #1;
        post_ok = !bus.done && !bus.busy;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic [19:0] exp_saddr;
        logic [3:0]  exp_be_n;
        int          exp_lat;
        int          exp_ce;
        int          exp_we;
        int          exp_oe;
        int          exp_busy;
    } vec_t;

    vec_t vt [11];

    int          lat, ce, we, oe, bsy;
    logic [19:0] sa;
    logic [3:0]  sbe;
    logic [31:0] rdv;
    logic        post_ok;
    int          n_done, second_at, oe_low;
    logic        early_done;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        mem[4] = 32'hDEADBEEF;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.byte_en   = '0;

        vt[0]  = '{1, 0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 20'h4,     4'hF, 2, 2, 0, 2, 3};
        vt[1]  = '{0, 1, 32'h20,       32'h12345678, 4'h3, 32'hDEADBEEF, 20'h8,     4'hC, 4, 4, 2, 0, 5};
        vt[2]  = '{1, 0, 32'h20,       32'h0,        4'h0, 32'hC0DE5678, 20'h8,     4'hF, 2, 2, 0, 2, 3};
        vt[3]  = '{0, 1, 32'h24,       32'hAABBCCDD, 4'h8, 32'hC0DE5678, 20'h9,     4'h7, 4, 4, 2, 0, 5};
        vt[4]  = '{1, 0, 32'h24,       32'h0,        4'h0, 32'hAADE0009, 20'h9,     4'hF, 2, 2, 0, 2, 3};
        vt[5]  = '{1, 1, 32'h30,       32'hFFFF0000, 4'hF, 32'hC0DE000C, 20'hC,     4'hF, 2, 2, 0, 2, 3};
        vt[6]  = '{0, 1, 32'h30,       32'hFFFF0000, 4'hF, 32'hC0DE000C, 20'hC,     4'h0, 4, 4, 2, 0, 5};
        vt[7]  = '{1, 0, 32'h30,       32'h0,        4'h0, 32'hFFFF0000, 20'hC,     4'hF, 2, 2, 0, 2, 3};
        vt[8]  = '{0, 1, 32'h40,       32'h11111111, 4'h0, 32'hFFFF0000, 20'h0,     4'hF, 0, 0, 0, 0, 1};
        vt[9]  = '{1, 0, 32'h40,       32'h0,        4'h0, 32'hC0DE0010, 20'h10,    4'hF, 2, 2, 0, 2, 3};
        vt[10] = '{1, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'hC0DE00FF, 20'hFFFFF, 4'hF, 2, 2, 0, 2, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n}, 7'h7F);
        chk("rst_ctl", {bus.sram_data_oe, bus.done, bus.busy}, 3'b000);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_addr_din", {bus.sram_addr, bus.sram_din}, 52'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 11; v++) begin
            access(vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].be,
                   lat, ce, we, oe, bsy, sa, sbe, rdv, post_ok);
            chk($sformatf("v%0d_lat", v), lat, vt[v].exp_lat);
            chk($sformatf("v%0d_rdata", v), rdv, vt[v].exp_rdata);
            chk($sformatf("v%0d_ce_cyc", v), ce, vt[v].exp_ce);
            chk($sformatf("v%0d_we_cyc", v), we, vt[v].exp_we);
            chk($sformatf("v%0d_oe_cyc", v), oe, vt[v].exp_oe);
            chk($sformatf("v%0d_busy_cyc", v), bsy, vt[v].exp_busy);
            chk($sformatf("v%0d_be_n", v), sbe, vt[v].exp_be_n);
            chk($sformatf("v%0d_done_1cyc", v), post_ok, 1'b1);
            if (vt[v].exp_ce != 0)
                chk($sformatf("v%0d_saddr", v), sa, vt[v].exp_saddr);
        end

        // reset asserted in the middle of the write pulse
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.addr      = 32'h50;
        bus.wdata     = 32'h0;
        bus.byte_en   = 4'hF;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!bus.sram_we_n) begin lat = i; break; end
        end
        chk("rstw_pulse_seen", (lat >= 0), 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstw_strobes", {bus.sram_we_n, bus.sram_ce_n, bus.sram_oe_n, bus.sram_data_oe}, 4'b1110);
        chk("rstw_done_busy", {bus.done, bus.busy}, 2'b00);
        bus.req_write = 1'b0;
        early_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) early_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) early_done = 1'b1;
        end
        chk("rstw_no_done", early_done, 1'b0);
        chk("rstw_rdata_clr", bus.rdata, 32'h0);
        access(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, lat, ce, we, oe, bsy, sa, sbe, rdv, post_ok);
        chk("rstw_readback", rdv, 32'hC0DE0014);
        chk("rstw_rb_lat", lat, 2);

        // read request held through done: second access starts after IDLE
        @(negedge clk);
        bus.req_read = 1'b1;
        bus.addr     = 32'h10;
        n_done = 0;
        second_at = -1;
        oe_low = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (!bus.sram_oe_n) oe_low++;
            if (bus.done) begin
                n_done++;
                if (n_done == 2) second_at = i;
            end
        end
        bus.req_read = 1'b0;
        chk("b2b_done_cnt", n_done, 2);
        chk("b2b_second_at", second_at, 6);
        chk("b2b_oe_cycles", oe_low, 4);
        chk("b2b_rdata", bus.rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_idle", {bus.busy, bus.done}, 2'b00);

        chk("mon_oe_we_overlap", v_overlap, 0);
        chk("mon_data_oe", v_doe, 0);
        chk("mon_we_stable", v_stable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
